// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the CPU/DMA memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int MAX_LOCK_DEF = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: CPU and DMA request/ack channels plus shared read data.
// The arbiter connects through 'slave', requesters through 'master'.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_lock;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;

  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;

  logic [DATA_W-1:0] rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output cpu_ack, dma_ack, rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  cpu_ack, dma_ack, rdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way picker: honours an active lock when the owner is
// requesting, otherwise round-robin on the pointer (ptr = port favoured).
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic ptr_i,
  input  logic lock_i,
  input  logic owner_i,
  output logic vld_o,
  output logic win_o
);

  logic owner_req;
  assign owner_req = (owner_i == OWN_DMA) ? dma_req_i : cpu_req_i;

  // Lock beats round-robin only while the owner keeps requesting.
  always_comb begin
    vld_o = cpu_req_i | dma_req_i;
    win_o = OWN_CPU;
    if (lock_i && owner_req)          win_o = owner_i;
    else if (cpu_req_i && dma_req_i)  win_o = ptr_i;
    else                              win_o = dma_req_i ? OWN_DMA : OWN_CPU;
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for a single synchronous 8-bit memory port.
// IDLE -> ACCESS (one strobe cycle) -> RESP (ack + rdata) -> IDLE.
// Define MEM_ARB_LOCK_EN to build the bounded bus-lock for bursts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;
  logic              rr_q;
  logic              mem_read_q, mem_write_q;
  logic              cpu_ack_q, dma_ack_q;

  logic              lock_eff;
  logic              gnt_vld, gnt_win;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              we_d;

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             lock_q;
  logic             sat;
  logic             lock_d;
  // Saturated counter forces one ordinary arbitration before the lock re-arms.
  assign sat      = (cnt_q == CNT_W'(MAX_LOCK));
  assign lock_eff = lock_q & ~sat;
  assign lock_d   = gnt_win ? bus.dma_lock : bus.cpu_lock;
`else
  localparam int unused_max_lock = MAX_LOCK;
  logic unused_lock;
  assign unused_lock = bus.cpu_lock ^ bus.dma_lock;
  assign lock_eff    = 1'b0;
`endif

  rr_pick2 u_pick (
    .cpu_req_i (bus.cpu_req),
    .dma_req_i (bus.dma_req),
    .ptr_i     (rr_q),
    .lock_i    (lock_eff),
    .owner_i   (owner_q),
    .vld_o     (gnt_vld),
    .win_o     (gnt_win)
  );

  assign addr_d  = gnt_win ? bus.dma_addr  : bus.cpu_addr;
  assign wdata_d = gnt_win ? bus.dma_wdata : bus.cpu_wdata;
  assign we_d    = gnt_win ? bus.dma_we    : bus.cpu_we;

  // Arbitration FSM; strobes and acks are registered so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      owner_q     <= OWN_CPU;
      rr_q        <= OWN_CPU;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
      cnt_q       <= '0;
      lock_q      <= 1'b0;
`endif
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            owner_q     <= gnt_win;
            rr_q        <= ~gnt_win;
            mem_read_q  <= ~we_d;
            mem_write_q <= we_d;
            state_q     <= ST_ACCESS;
`ifdef MEM_ARB_LOCK_EN
            lock_q      <= lock_d;
            if (sat || (gnt_win != owner_q)) cnt_q <= '0;
`endif
          end
        end
        ST_ACCESS: begin
          cpu_ack_q <= (owner_q == OWN_CPU);
          dma_ack_q <= (owner_q == OWN_DMA);
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
`ifdef MEM_ARB_LOCK_EN
          if (lock_q) cnt_q <= sat ? cnt_q : cnt_q + CNT_W'(1);
          else        cnt_q <= '0;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign owner       = owner_q;
  assign bus.cpu_ack = cpu_ack_q;
  assign bus.dma_ack = dma_ack_q;
  // Memory data arrives in the RESP cycle, so it is passed straight through.
  assign bus.rdata   = ((cpu_ack_q | dma_ack_q) & ~we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers feed per-port transaction queues,
// expected acks are queued in grant order, a monitor pops on every ack.
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read, mem_write;
  logic [7:0]  mem_rdata;
  logic        owner;

  logic [7:0]  mem [0:65535];

  txn_t cq[$];
  txn_t dq[$];
  exp_t expq[$];
  int   ackq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic        cpu_man = 1'b0;
  logic        man_req = 1'b0;
  logic [15:0] man_addr = '0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // synchronous memory: read data appears the cycle after mem_read
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= mem[mem_addr];
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // requester drivers: hold the head transaction until its ack
  always @(negedge clk) begin
    if (cpu_man) begin
      bus.cpu_req = man_req; bus.cpu_we = 1'b0; bus.cpu_lock = 1'b0;
      bus.cpu_addr = man_addr; bus.cpu_wdata = '0;
    end else begin
      if (bus.cpu_ack && cq.size() > 0) void'(cq.pop_front());
      if (cq.size() > 0) begin
        bus.cpu_req = 1'b1; bus.cpu_we = cq[0].we; bus.cpu_lock = cq[0].lock;
        bus.cpu_addr = cq[0].addr; bus.cpu_wdata = cq[0].wdata;
      end else bus.cpu_req = 1'b0;
    end
    if (bus.dma_ack && dq.size() > 0) void'(dq.pop_front());
    if (dq.size() > 0) begin
      bus.dma_req = 1'b1; bus.dma_we = dq[0].we; bus.dma_lock = dq[0].lock;
      bus.dma_addr = dq[0].addr; bus.dma_wdata = dq[0].wdata;
    end else bus.dma_req = 1'b0;
  end

  // monitor: every ack must match the next expected grant
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.cpu_ack || bus.dma_ack) begin
      ackq.push_back(cyc);
      if (expq.size() == 0) chk("unexpected_ack", {30'd0, bus.dma_ack, bus.cpu_ack}, 32'd0);
      else begin
        e = expq.pop_front();
        chk("ack_port", {30'd0, bus.dma_ack, bus.cpu_ack}, e.port ? 32'd2 : 32'd1);
        chk("ack_rdata", {24'd0, bus.rdata}, {24'd0, e.data});
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((cq.size() + dq.size() + expq.size()) != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    chk("drain_timeout", cq.size() + dq.size() + expq.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic txn_t rd(input logic [15:0] a, input logic lk);
    txn_t t; t.we = 1'b0; t.lock = lk; t.addr = a; t.wdata = '0; return t;
  endfunction

  function automatic exp_t ex(input logic p, input logic [7:0] d);
    exp_t e; e.port = p; e.data = d; return e;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nr, wc;
    logic [15:0] wa;
    logic [7:0]  wd;
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_lock = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_lock = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));
    mem[16'h0010] = 8'hA5; mem[16'h0020] = 8'h5A; mem[16'h0030] = 8'h77;
    for (int i = 0; i < 8; i++) begin
      mem[16'h0100 + i] = 8'h40 + 8'(i);
      mem[16'h0200 + i] = 8'h80 + 8'(i);
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_owner", owner, 0);
    chk("rst_acks", {bus.dma_ack, bus.cpu_ack}, 0);
    reset = 1'b0;

    // CPU read latency
    sync();
    cq.push_back(rd(16'h0010, 1'b0)); expq.push_back(ex(1'b0, 8'hA5));
    @(negedge clk); @(negedge clk);
    chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    chk("t1_owner", owner, 0);
    chk("t1_early_ack", bus.cpu_ack, 0);
    @(negedge clk);
    chk("t1_cpu_ack", bus.cpu_ack, 1);
    drain(20);

    // DMA write: one strobe cycle, ack next cycle
    sync();
    begin
      txn_t t; t.we = 1'b1; t.lock = 1'b0; t.addr = 16'h1234; t.wdata = 8'h3C;
      dq.push_back(t);
    end
    expq.push_back(ex(1'b1, 8'h00));
    nw = 0; nr = 0; wc = 0; wa = '0; wd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_write) begin nw++; wa = mem_addr; wd = mem_wdata; wc = cyc; end
      if (mem_read) nr++;
    end
    drain(20);
    chk("t2_write_cycles", nw, 1);
    chk("t2_read_cycles", nr, 0);
    chk("t2_addr", wa, 16'h1234);
    chk("t2_wdata", wd, 8'h3C);
    chk("t2_ack_delay", ackq[ackq.size()-1] - wc, 1);
    chk("t2_owner", owner, 1);
    chk("t2_mem", mem[16'h1234], 8'h3C);

    // read back the written byte
    sync();
    cq.push_back(rd(16'h1234, 1'b0)); expq.push_back(ex(1'b0, 8'h3C));
    drain(20);

    // simultaneous continuous requests after reset: alternate, 3 cycles apart
    do_reset();
    ackq.delete();
    sync();
    for (int i = 0; i < 4; i++) begin
      cq.push_back(rd(16'h0200 + 16'(i), 1'b0));
      dq.push_back(rd(16'h0100 + 16'(i), 1'b0));
      expq.push_back(ex(1'b0, 8'h80 + 8'(i)));
      expq.push_back(ex(1'b1, 8'h40 + 8'(i)));
    end
    drain(60);
    chk("t4_ack_count", ackq.size(), 8);
    for (int i = 1; i < 8 && i < ackq.size(); i++) chk("t4_ack_spacing", ackq[i] - ackq[i-1], 3);

    // DMA locked burst with CPU competing
    do_reset();
    sync();
    for (int i = 0; i < 6; i++) dq.push_back(rd(16'h0100 + 16'(i), 1'b1));
`ifdef MEM_ARB_LOCK_EN
    expq.push_back(ex(1'b1, 8'h40)); expq.push_back(ex(1'b1, 8'h41));
    expq.push_back(ex(1'b1, 8'h42)); expq.push_back(ex(1'b1, 8'h43));
    expq.push_back(ex(1'b0, 8'h80)); expq.push_back(ex(1'b1, 8'h44));
    expq.push_back(ex(1'b1, 8'h45)); expq.push_back(ex(1'b0, 8'h81));
`else
    expq.push_back(ex(1'b1, 8'h40)); expq.push_back(ex(1'b0, 8'h80));
    expq.push_back(ex(1'b1, 8'h41)); expq.push_back(ex(1'b0, 8'h81));
    expq.push_back(ex(1'b1, 8'h42)); expq.push_back(ex(1'b1, 8'h43));
    expq.push_back(ex(1'b1, 8'h44)); expq.push_back(ex(1'b1, 8'h45));
`endif
    sync();
    cq.push_back(rd(16'h0200, 1'b0));
    cq.push_back(rd(16'h0201, 1'b0));
    drain(80);

    // reset during ACCESS aborts without ack; the held request then completes
    sync();
    cq.push_back(rd(16'h0020, 1'b0)); expq.push_back(ex(1'b0, 8'h5A));
    @(negedge clk); @(negedge clk);
    chk("t6_strobe_before_rst", mem_read, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_read", mem_read, 0);
    chk("t6_rst_write", mem_write, 0);
    chk("t6_rst_acks", {bus.dma_ack, bus.cpu_ack}, 0);
    chk("t6_rst_addr", mem_addr, 0);
    reset = 1'b0;
    drain(20);

    // CPU drops req during ACCESS: ack still pulses, then FSM idles
    cpu_man = 1'b1;
    sync();
    man_req = 1'b1; man_addr = 16'h0030; expq.push_back(ex(1'b0, 8'h77));
    @(negedge clk);
    sync();
    man_req = 1'b0;
    @(negedge clk);
    chk("t7_mem_read", mem_read, 1);
    @(negedge clk);
    chk("t7_cpu_ack", bus.cpu_ack, 1);
    @(negedge clk); @(negedge clk);
    chk("t7_idle_strobes", {mem_write, mem_read}, 0);
    drain(10);
    cpu_man = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 8-bit synchronous memory port between the processor core (CPU port) and a loader/DMA engine (DMA port). The arbiter owns all memory strobes and the memory address, and serialises accesses through a 3-state FSM. Fairness is round-robin, with an optional bounded bus lock for bursts. It sits between the requesters and `memory_file_load`, replacing direct control-unit drive of `mem_read`/`mem_write`.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `MAX_LOCK`, 16, max consecutive locked grants to one owner (≥1)

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_req` / `dma_req`  in  1  access request, held until ack
- `cpu_we` / `dma_we`  in  1  1 = write, 0 = read
- `cpu_lock` / `dma_lock`  in  1  keep ownership after this access
- `cpu_addr` / `dma_addr`  in  ADDR_W  access address
- `cpu_wdata` / `dma_wdata`  in  DATA_W  write data
- `cpu_ack` / `dma_ack`  out  1  one-cycle completion pulse
- `rdata`  out  DATA_W  read data, valid with ack (shared by both ports)
- `mem_addr`  out  ADDR_W  to memory
- `mem_wdata`  out  DATA_W  to memory
- `mem_read` / `mem_write`  out  1  memory strobes
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_read`
- `owner`  out  1  0 = CPU, 1 = DMA; last/current grantee

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If no request, stay in IDLE.
  - Otherwise pick a winner and latch its addr/we/wdata/lock into internal registers. Set `owner`. Go to ACCESS.
- **Pick rule:**
  - Lock active (see Configuration): only the owner is eligible. If the owner is not requesting, the lock drops and normal arbitration applies.
  - Single requester: that requester wins.
  - Both requesting: the winner is the port not granted last (round-robin pointer). After reset the pointer favours CPU.
- **ACCESS:** drive `mem_addr`/`mem_wdata` from the latched registers. Assert `mem_read` (we=0) or `mem_write` (we=1) for exactly this cycle. Go to RESP.
- **RESP:**
  - Pulse the winner's ack.
  - `rdata` ← `mem_rdata` for reads; ← 0 for writes.
  - Update lock state. Go to IDLE.
- **Requester rules:**
  - The request must stay stable until ack.
  - In the cycle after ack, the requester deasserts req or presents a new request.
  - Dropping req before ack is illegal. The latched access still completes and ack still pulses.
- **Outputs outside ACCESS:** `mem_read` = `mem_write` = 0. `mem_addr`/`mem_wdata` hold their latched values.
- **Widths:** no arithmetic on addresses; addresses pass through unmodified. Lock counter is $clog2(MAX_LOCK+1) bits, saturating.

## Timing
- **Reset values:**
  - State IDLE
  - All acks 0, `mem_read`/`mem_write` 0
  - `mem_addr` 0, `mem_wdata` 0, `rdata` 0
  - `owner` 0, RR pointer favours CPU, lock counter 0
- **Latency:** req seen in IDLE at cycle N → strobe in cycle N+1 → ack and `rdata` in cycle N+2.
- **Throughput:** one access per 3 cycles. Back-to-back requests re-enter IDLE in cycle N+3.
- **Simultaneous requests at IDLE:** exactly one is granted; the other waits ≤ 3 cycles when no lock is active.
- **Reset mid-operation:**
  - Any state goes to IDLE on the next edge.
  - A strobe already asserted in the reset cycle is not retracted; memory may complete that write.
  - No ack is issued for the aborted access.

## Configuration
- Macro `MEM_ARB_LOCK_EN`.
- **Defined:**
  - A locked grant (lock=1 latched) keeps ownership for the next IDLE decision and increments the lock counter.
  - When the counter reaches `MAX_LOCK`, the lock is ignored for one arbitration and the counter clears; the RR pointer then favours the other port.
  - Unlocked grant or owner switch clears the counter.
- **Undefined:** `*_lock` inputs are ignored, no counter is built, and arbitration is pure round-robin.

## Structure
- Package `mem_arb_pkg`:
  - State encoding (ST_IDLE, ST_ACCESS, ST_RESP)
  - Owner encoding (OWN_CPU=0, OWN_DMA=1)
  - Default `MAX_LOCK`
- Sub-module `rr_pick2`: combinational 2-way round-robin picker.
  - Inputs: both reqs, pointer, lock-active, owner.
  - Outputs: grant valid, winner.
  - FSM, latches and the counter stay in `mem_arbiter`.

## Test plan
- Reset, then CPU read of 0x0010 (mem holds 0xA5) → `mem_read`=1 in cycle 1, `cpu_ack`=1 and `rdata`=0xA5 in cycle 2, `owner`=0.
- Both request at the same cycle after reset, continuously, no lock → grants alternate CPU, DMA, CPU, DMA…; each ack 3 cycles apart.
- DMA write 0x3C to 0x1234 → `mem_write` for exactly 1 cycle with those values, `dma_ack` next cycle, `rdata`=0.
- With `MEM_ARB_LOCK_EN`, `MAX_LOCK`=4, DMA locked burst while CPU requests → 4 DMA grants, then CPU granted; without the macro, strict alternation.
- Reset asserted in the ACCESS cycle → IDLE next cycle, no ack, strobes 0; a subsequent request completes normally.
- CPU drops req while in ACCESS → `cpu_ack` still pulses in RESP; the next IDLE cycle with no requests stays IDLE.
